fault_campaign_seq: RTL and testbench

//  Sequences a fault-injection campaign on the dual-DUT scan system.
//  For each fault pattern PAT_FIRST..PAT_LAST: clear SIPO, serially scan the pattern in, enable

---
 rtl/fault_campaign_seq.sv | 191 +++++++++++++++++++
 tb/tb_fault_campaign_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_campaign_seq.sv
// Fault-injection campaign sequencer: per pattern clear SIPO, scan in, sweep vectors, count Y0/Y1 diversity.
// Optional fault-free reference pass before the first pattern when GOLDEN_PASS_EN is defined.
module fault_campaign_seq #(
  parameter int unsigned PAT_W  = 16,
  parameter int unsigned VEC_W  = 4,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned TOT_W  = 24
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [PAT_W-1:0]   PAT_FIRST,
  input  logic [PAT_W-1:0]   PAT_LAST,
  output logic               BUSY,
  output logic               DONE,
  output logic               SIPO_CLEAR,
  output logic               SCAN_ENABLE,
  output logic               SCAN_IN,
  output logic               TRI_E,
  output logic [VEC_W-1:0]   VEC_OUT,
  input  logic               Y0,
  input  logic               Y1,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [PAT_W-1:0]   RES_PAT,
  output logic [VEC_W:0]     RES_MISS,
  output logic               RES_GOLDEN,
  output logic [TOT_W-1:0]   TOTAL_MISS
);

`ifdef GOLDEN_PASS_EN
  localparam logic GOLDEN_EN = 1'b1;
`else
  localparam logic GOLDEN_EN = 1'b0;
`endif

  localparam int unsigned SH_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_APPLY,
    S_REPORT
  } state_t;

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   cur_pat;
  logic [PAT_W-1:0]   pat_last;
  logic [PAT_W-1:0]   shreg;
  logic [SH_W-1:0]    shift_cnt;
  logic [VEC_W-1:0]   vec_cnt;
  logic [SET_W-1:0]   settle_cnt;
  logic [VEC_W:0]     res_miss;
  logic [TOT_W-1:0]   total_miss;
  logic               golden_q;
  logic               done_q;

  logic               shift_last;
  logic               settle_last;
  logic               vec_last;
  logic               accept;
  logic               pat_is_last;
  logic [TOT_W:0]     tot_sum;
  logic [TOT_W-1:0]   tot_sat;

  always_comb begin
    shift_last  = (shift_cnt == SH_W'(PAT_W - 1));
    settle_last = (settle_cnt == SET_W'(SETTLE));
    vec_last    = (vec_cnt == '1);
    accept      = (state == S_REPORT) && RES_READY;
    pat_is_last = (cur_pat == pat_last);
    tot_sum     = {1'b0, total_miss} + {{(TOT_W - VEC_W){1'b0}}, res_miss};
    tot_sat     = tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
  end

  always_comb begin
    state_nxt   = state;
    BUSY        = (state != S_IDLE);
    DONE        = done_q;
    SIPO_CLEAR  = 1'b0;
    SCAN_ENABLE = 1'b0;
    SCAN_IN     = 1'b0;
    TRI_E       = 1'b0;
    VEC_OUT     = '0;
    RES_VALID   = 1'b0;
    RES_PAT     = golden_q ? '0 : cur_pat;
    RES_MISS    = res_miss;
    RES_GOLDEN  = 1'b0;
    TOTAL_MISS  = total_miss;
    case (state)
      S_IDLE: begin
        if (START) state_nxt = GOLDEN_EN ? S_APPLY : S_CLEAR;
      end
      S_CLEAR: begin
        SIPO_CLEAR = 1'b1;
        state_nxt  = S_SHIFT;
      end
      S_SHIFT: begin
        SCAN_ENABLE = 1'b1;
        SCAN_IN     = shreg[PAT_W-1];
        if (shift_last) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        TRI_E   = ~golden_q;
        VEC_OUT = vec_cnt;
        if (vec_last && settle_last) state_nxt = S_REPORT;
      end
      S_REPORT: begin
        RES_VALID  = 1'b1;
        RES_GOLDEN = golden_q;
        if (RES_READY) begin
          if (golden_q || !pat_is_last) state_nxt = S_CLEAR;
          else                          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cur_pat    <= '0;
      pat_last   <= '0;
      shreg      <= '0;
      shift_cnt  <= '0;
      vec_cnt    <= '0;
      settle_cnt <= '0;
      res_miss   <= '0;
      total_miss <= '0;
      golden_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            cur_pat    <= PAT_FIRST;
            pat_last   <= PAT_LAST;
            total_miss <= '0;
            res_miss   <= '0;
            golden_q   <= GOLDEN_EN;
            vec_cnt    <= '0;
            settle_cnt <= '0;
          end
        end
        S_CLEAR: begin
          shreg      <= cur_pat;
          shift_cnt  <= '0;
          vec_cnt    <= '0;
          settle_cnt <= '0;
        end
        S_SHIFT: begin
          shreg     <= shreg << 1;
          shift_cnt <= shift_cnt + 1'b1;
        end
        S_APPLY: begin
          // Diversity is sampled only on the final settle cycle of each vector.
          if (settle_last) begin
            settle_cnt <= '0;
            vec_cnt    <= vec_cnt + 1'b1;
            res_miss   <= res_miss + {{VEC_W{1'b0}}, Y0 ^ Y1};
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_REPORT: begin
          if (RES_READY) begin
            golden_q <= 1'b0;
            if (golden_q) begin
              res_miss <= '0;
            end else begin
              total_miss <= tot_sat;
              if (pat_is_last) begin
                done_q <= 1'b1;
              end else begin
                cur_pat  <= cur_pat + 1'b1;
                res_miss <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_campaign_seq.sv
// Scoreboard bench for fault_campaign_seq: directed campaigns, expected results queued, monitor checks handshakes.
module tb_fault_campaign_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] PAT_FIRST, PAT_LAST;
  logic        BUSY, DONE, SIPO_CLEAR, SCAN_ENABLE, SCAN_IN, TRI_E;
  logic [3:0]  VEC_OUT;
  logic        Y0, Y1;
  logic        RES_VALID, RES_READY;
  logic [15:0] RES_PAT;
  logic [4:0]  RES_MISS;
  logic        RES_GOLDEN;
  logic [23:0] TOTAL_MISS;

  always #5 CLK = ~CLK;

  fault_campaign_seq #(.PAT_W(16), .VEC_W(4), .SETTLE(1), .TOT_W(24)) dut (
    .CLK(CLK), .RST(RST), .START(START), .PAT_FIRST(PAT_FIRST), .PAT_LAST(PAT_LAST),
    .BUSY(BUSY), .DONE(DONE), .SIPO_CLEAR(SIPO_CLEAR), .SCAN_ENABLE(SCAN_ENABLE),
    .SCAN_IN(SCAN_IN), .TRI_E(TRI_E), .VEC_OUT(VEC_OUT), .Y0(Y0), .Y1(Y1),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_PAT(RES_PAT), .RES_MISS(RES_MISS),
    .RES_GOLDEN(RES_GOLDEN), .TOTAL_MISS(TOTAL_MISS)
  );

`ifdef GOLDEN_PASS_EN
  localparam int GOLD = 1;
`else
  localparam int GOLD = 0;
`endif

  // DUT pair model: mode 0 identical, mode 1 differ on odd vectors, mode 2 differ when B&C; only under injection
  int mode = 0;
  always_comb begin
    Y0 = ^VEC_OUT;
    case (mode)
      1:       Y1 = Y0 ^ (TRI_E & VEC_OUT[0]);
      2:       Y1 = Y0 ^ (TRI_E & VEC_OUT[1] & VEC_OUT[2]);
      default: Y1 = Y0;
    endcase
  end

  logic [15:0] sipo;
  always @(posedge CLK) begin
    if (SIPO_CLEAR)       sipo <= '0;
    else if (SCAN_ENABLE) sipo <= {sipo[14:0], SCAN_IN};
  end

  typedef struct packed {
    logic        golden;
    logic [15:0] pat;
    logic [4:0]  miss;
  } res_t;
  res_t sb[$];

  int n_vec = 0, n_bad = 0, n_hs = 0, n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (DONE) n_done++;
      if (RES_VALID && RES_READY) begin
        n_hs++;
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result: got pat %h miss %0d, expected none", RES_PAT, RES_MISS);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("res_golden", {31'd0, RES_GOLDEN}, {31'd0, e.golden});
          chk("res_pat", {16'd0, RES_PAT}, {16'd0, e.pat});
          chk("res_miss", {27'd0, RES_MISS}, {27'd0, e.miss});
          if (!e.golden) chk("sipo_contents", {16'd0, sipo}, {16'd0, e.pat});
        end
      end
    end
  end

  task automatic expect_run(input logic [15:0] first, input logic [15:0] last,
                            input logic [4:0] miss, output int cnt);
    logic [15:0] p;
    res_t r;
    if (GOLD != 0) begin
      r = '{golden: 1'b1, pat: 16'h0, miss: 5'd0};
      sb.push_back(r);
    end
    p   = first;
    cnt = 0;
    for (int i = 0; i < 70000; i++) begin
      r = '{golden: 1'b0, pat: p, miss: miss};
      sb.push_back(r);
      cnt++;
      if (p == last) break;
      p = p + 16'd1;
    end
  endtask

  task automatic start_campaign(input logic [15:0] first, input logic [15:0] last);
    @(negedge CLK);
    PAT_FIRST = first;
    PAT_LAST  = last;
    START     = 1'b1;
    @(negedge CLK);
    START     = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit ok);
    n = 0;
    while (!DONE && n < limit) begin
      @(negedge CLK);
      n++;
    end
    ok = DONE;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no DONE after %0d cycles, expected DONE", n);
    end
  endtask

  task automatic run(input logic [15:0] first, input logic [15:0] last, input int mode_i,
                     input logic [4:0] miss, input int exp_lat);
    int cnt, n, hs0, dn0;
    bit ok;
    mode = mode_i;
    expect_run(first, last, miss, cnt);
    hs0 = n_hs;
    dn0 = n_done;
    start_campaign(first, last);
    wait_done((cnt + 2) * 60 + 100, n, ok);
    if (ok) begin
      if (exp_lat != 0) chk("done_latency", n, exp_lat + GOLD * 33);
      chk("total_miss", {8'd0, TOTAL_MISS}, cnt * miss);
      chk("busy_at_done", {31'd0, BUSY}, 0);
    end
    @(negedge CLK);
    chk("handshakes", n_hs - hs0, cnt + GOLD);
    chk("done_pulses", n_done - dn0, 1);
    chk("queue_empty", sb.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt, n, dn0;
    bit ok;
    logic [15:0] p0;
    logic [4:0]  m0;
    RST = 1'b1; START = 1'b1; RES_READY = 1'b1;
    PAT_FIRST = 16'h1111; PAT_LAST = 16'h2222;

    // Reset, with START asserted during reset
    repeat (2) @(negedge CLK);
    chk("reset_ctrl", {24'd0, BUSY, DONE, SIPO_CLEAR, SCAN_ENABLE, SCAN_IN, TRI_E, RES_VALID, RES_GOLDEN}, 0);
    chk("reset_data", {3'd0, VEC_OUT, RES_PAT, RES_MISS}, 0);
    chk("reset_total", {8'd0, TOTAL_MISS}, 0);
    RST = 1'b0; START = 1'b0;
    @(negedge CLK);
    chk("idle_after_reset", {31'd0, BUSY}, 0);

    // Single pattern, identical DUTs
    run(16'hA5C3, 16'hA5C3, 0, 5'd0, 50);
    // Mismatch counting over three patterns
    run(16'h0000, 16'h0002, 1, 5'd8, 0);

    // Backpressure: hold RES_READY low, START pulses while busy ignored
    mode = 2;
    expect_run(16'h1234, 16'h1235, 5'd4, cnt);
    RES_READY = 1'b0;
    start_campaign(16'h1234, 16'h1235);
    n = 0;
    while (!RES_VALID && n < 200) begin @(negedge CLK); n++; end
    chk("bp_valid_seen", {31'd0, RES_VALID}, 1);
    p0 = RES_PAT;
    m0 = RES_MISS;
    chk("bp_first_pat", {16'd0, p0}, (GOLD != 0) ? 32'h0 : 32'h1234);
    chk("bp_first_miss", {27'd0, m0}, (GOLD != 0) ? 32'd0 : 32'd4);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin PAT_FIRST = 16'h0000; PAT_LAST = 16'h0000; START = 1'b1; end
      else        START = 1'b0;
      @(negedge CLK);
      if (RES_VALID !== 1'b1 || RES_PAT !== p0 || RES_MISS !== m0 || SIPO_CLEAR !== 1'b0) begin
        n_vec++; n_bad++;
        $display("FAIL bp_hold: got valid %b pat %h miss %0d clr %b, expected 1 %h %0d 0",
                 RES_VALID, RES_PAT, RES_MISS, SIPO_CLEAR, p0, m0);
      end else n_vec++;
    end
    START = 1'b0;
    RES_READY = 1'b1;
    wait_done(400, n, ok);
    if (ok) chk("bp_total", {8'd0, TOTAL_MISS}, 8);
    @(negedge CLK);
    chk("bp_queue_empty", sb.size(), 0);

    // Pattern wrap through all-ones
    run(16'hFFFE, 16'h0001, 2, 5'd4, 0);

    // Abort mid-SHIFT
    mode = 1;
    if (GOLD != 0) begin
      res_t r;
      r = '{golden: 1'b1, pat: 16'h0, miss: 5'd0};
      sb.push_back(r);
    end
    start_campaign(16'h00F0, 16'h00F0);
    n = 0;
    while (!SCAN_ENABLE && n < 200) begin @(negedge CLK); n++; end
    chk("abort_in_shift", {31'd0, SCAN_ENABLE}, 1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_scan_en", {31'd0, SCAN_ENABLE}, 0);
    chk("abort_busy", {31'd0, BUSY}, 0);
    dn0 = n_done;
    RST = 1'b0;
    repeat (60) @(negedge CLK);
    chk("abort_no_done", n_done - dn0, 0);
    chk("abort_idle", {31'd0, BUSY}, 0);
    chk("abort_queue", sb.size(), 0);
    sb.delete();

    // Clean restart after abort
    run(16'h0003, 16'h0003, 1, 5'd8, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
